// File: rtl/l2_arbiter.sv
// Two-port L2 arbiter: grants the L1 I-cache or D-cache miss port and holds the latched request until L2 responds.
// Optional build macro L2_ARB_DPRIO_EN makes the D-cache win every tie instead of round-robin.
module l2_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  op_read_q, op_read_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
`ifndef L2_ARB_DPRIO_EN
    logic                  last_grant_q, last_grant_d;
`endif

    logic i_req, d_req, pick_d, serving;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef L2_ARB_DPRIO_EN
    assign pick_d = d_req;
`else
    // On a tie, grant whichever port did not win last time.
    assign pick_d = d_req & (~i_req | ~last_grant_q);
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_read_d  = op_read_q;
        op_write_d = op_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifndef L2_ARB_DPRIO_EN
        last_grant_d = last_grant_q;
`endif
        i_resp = 1'b0;
        d_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d    = SERVE_D;
                    addr_d     = d_address;
                    wdata_d    = d_wdata;
                    op_read_d  = d_read;
                    op_write_d = d_write;
                end else if (i_req) begin
                    state_d    = SERVE_I;
                    addr_d     = i_address;
                    op_read_d  = 1'b1;
                    op_write_d = 1'b0;
                end
            end
            SERVE_I: begin
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = RELEASE;
`ifndef L2_ARB_DPRIO_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = RELEASE;
`ifndef L2_ARB_DPRIO_EN
                    last_grant_d = 1'b1;
`endif
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees the pre-edge value of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifndef L2_ARB_DPRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            op_read_q  <= op_read_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
`ifndef L2_ARB_DPRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Downstream controls decode registered state only; requests never reach mem_* combinationally.
    assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign mem_read    = serving & op_read_q;
    assign mem_write   = serving & op_write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected L2 transactions are queued at request time and
// compared when the arbiter drives them downstream; response routing is checked on each completion.
module tb_l2_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read, d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    typedef struct {
        logic          port;  // 0 = I, 1 = D
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    function automatic txn_t mk(input logic port, input logic rd, input logic wr,
                                input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        txn_t t;
        t.port = port; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    // Wait for a downstream request, pop the expected transaction and compare it.
    task automatic await_grant(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(mem_read || mem_write) && waited < 16);
        vectors++;
        if (!(mem_read || mem_write) || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL grant_seen: got rd=%b wr=%b queued=%0d after %0d cycles, want a queued request",
                     mem_read, mem_write, exp_q.size(), waited);
            return;
        end
        cur = exp_q.pop_front();
        vectors++;
        if (mem_read !== cur.rd || mem_write !== cur.wr) begin
            miscompares++;
            $display("FAIL grant_op: got rd=%b wr=%b want rd=%b wr=%b", mem_read, mem_write, cur.rd, cur.wr);
        end
        vectors++;
        if (mem_address !== cur.addr) begin
            miscompares++;
            $display("FAIL grant_addr: got %h want %h", mem_address, cur.addr);
        end
        if (cur.wr) begin
            vectors++;
            if (mem_wdata !== cur.wdata) begin
                miscompares++;
                $display("FAIL grant_wdata: got %h want %h", mem_wdata, cur.wdata);
            end
        end
    endtask

    // Complete the current transaction and check routing, then the dead RELEASE cycle.
    task automatic respond(input logic [LW-1:0] data);
        mem_rdata = data;
        mem_resp  = 1'b1;
        #1;
        vectors++;
        if (i_resp !== !cur.port || d_resp !== cur.port) begin
            miscompares++;
            $display("FAIL resp_route: got i_resp=%b d_resp=%b want i_resp=%b d_resp=%b",
                     i_resp, d_resp, !cur.port, cur.port);
        end
        vectors++;
        if ((cur.port ? d_rdata : i_rdata) !== data) begin
            miscompares++;
            $display("FAIL resp_data: got %h want %h", cur.port ? d_rdata : i_rdata, data);
        end
        @(negedge clk);
        mem_resp = 1'b0;
        #1;
        vectors++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL release: got rd=%b wr=%b i_resp=%b d_resp=%b want all 0",
                     mem_read, mem_write, i_resp, d_resp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== '0 || mem_wdata !== '0
            || i_resp !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wdata_nz=%b i_resp=%b d_resp=%b want all 0",
                     mem_read, mem_write, mem_address, |mem_wdata, i_resp, d_resp);
        end
    endtask

    task automatic test_single_i();
        int w;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0));
        i_read = 1'b1; i_address = 32'h0000_1000;
        await_grant(w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("FAIL single_i_latency: got %0d want 1", w);
        end
        i_read = 1'b0;
        respond({32{8'hA5}});
    endtask

    task automatic test_d_writeback();
        int w;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_2000, {8{32'hDEAD_BEEF}}));
        d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = {8{32'hDEAD_BEEF}};
        await_grant(w);
        d_write = 1'b0; d_wdata = '0;
        repeat (2) @(negedge clk);
        respond(rand_line());
    endtask

    task automatic test_tie();
        int w;
        do_reset();
        for (int k = 0; k < 3; k++) begin
`ifdef L2_ARB_DPRIO_EN
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0));
`else
            if (k == 1) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_5000, '0));
            else        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_6000, '0));
`endif
        end
        i_read = 1'b1; i_address = 32'h0000_6000;
        d_read = 1'b1; d_address = 32'h0000_5000;
        for (int k = 0; k < 3; k++) begin
            await_grant(w);
            vectors++;
            if (w !== (k == 0 ? 1 : 2)) begin
                miscompares++;
                $display("FAIL tie_turnaround[%0d]: got %0d want %0d", k, w, k == 0 ? 1 : 2);
            end
            if (k == 2) begin
                i_read = 1'b0; d_read = 1'b0;
            end
            respond(rand_line());
        end
    endtask

    task automatic test_withdrawal();
        int w;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_3000, '0));
        d_read = 1'b1; d_address = 32'h0000_3000;
        await_grant(w);
        @(negedge clk);
        d_read = 1'b0; d_address = 32'h0000_9999;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (mem_read !== 1'b1 || mem_address !== 32'h0000_3000) begin
                miscompares++;
                $display("FAIL withdraw_hold[%0d]: got rd=%b addr=%h want rd=1 addr=00003000",
                         k, mem_read, mem_address);
            end
        end
        respond(rand_line());
    endtask

    task automatic test_spurious();
        int w;
        @(negedge clk);
        mem_resp = 1'b1;
        #1;
        vectors++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_idle: got i_resp=%b d_resp=%b want 0 0", i_resp, d_resp);
        end
        @(negedge clk);
        mem_resp = 1'b0;
        vectors++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_idle_state: got rd=%b wr=%b want 0 0", mem_read, mem_write);
        end
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_7000, '0));
        i_read = 1'b1; i_address = 32'h0000_7000;
        await_grant(w);
        i_read = 1'b0;
        respond(rand_line());
        // Now in RELEASE: a stray completion must be ignored.
        mem_resp = 1'b1;
        #1;
        vectors++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_release: got i_resp=%b d_resp=%b want 0 0", i_resp, d_resp);
        end
        @(negedge clk);
        mem_resp = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0000_8000, {8{32'h1234_5678}}));
        d_write = 1'b1; d_address = 32'h0000_8000; d_wdata = {8{32'h1234_5678}};
        await_grant(w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("FAIL spurious_release_latency: got %0d want 1", w);
        end
        d_write = 1'b0;
        respond(rand_line());
    endtask

    task automatic test_reset_mid_serve();
        int w;
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0000_A000, '0));
        i_read = 1'b1; i_address = 32'h0000_A000;
        await_grant(w);
        i_read = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0000_4000, '0));
        d_read = 1'b1; d_address = 32'h0000_4000;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_read !== 1'b0 || mem_address !== '0 || i_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_serve: got rd=%b addr=%h i_resp=%b want 0 0 0", mem_read, mem_address, i_resp);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        await_grant(w);
        vectors++;
        if (w !== 1) begin
            miscompares++;
            $display("FAIL reset_regrant_latency: got %0d want 1", w);
        end
        d_read = 1'b0;
        respond(rand_line());
    endtask

    initial begin
        test_reset();
        test_single_i();
        test_d_writeback();
        test_tie();
        test_withdrawal();
        test_spurious();
        test_reset_mid_serve();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
